// File: rtl/module_uart_tx_mmio.sv
// module_uart_tx_mmio
// Memory-mapped 8N1 UART transmitter that sits on the single-cycle processor's
// data bus next to the data RAM. A store to TXDATA latches a byte. A store of
// SEND to CTRL launches a serial frame. Loads return status or the latched byte.
//
// Parameters:
//   BASE_ADDR - word-aligned base of the 8-byte register window
//   BAUD_DIV  - clock cycles per serial bit (2..65535)
//
// Ports:
//   clk_i    - system clock (shared with processor and RAM)
//   rst_i    - synchronous reset, active low
//   we_i     - processor store strobe
//   addr_i   - processor data address
//   wdata_i  - processor store data
//   rdata_o  - combinational read data, 0 when the window is not addressed
//   hit_o    - combinational window decode
//   tx_o     - serial line, idles high (registered)
//   busy_o   - frame in progress (registered)
//
// Register map (word offset = addr_i[2]):
//   0x0 CTRL/STATUS  write: bit0 SEND, bit2 clear DONE (W1C)
//                    read : {29'b0, DONE, BUSY, 1'b0}
//   0x4 TXDATA       write: latch wdata_i[7:0]; read: {24'b0, txdata}

module module_uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned BAUD_DIV  = 87
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        hit_o,
  output logic        tx_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Counter value on the final cycle of each serial bit.
  localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  txdata_q, txdata_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        wr_ctrl;
  logic        wr_data;
  logic        send_req;
  logic        done_clr;
  logic        done_set;
  logic        bit_end;

  // Only bits 0, 1..7 and 2 of the store data, and the word-level address bits,
  // carry meaning; the rest are deliberately ignored.
  logic        unused_bits;
  assign unused_bits = ^{wdata_i[31:8], addr_i[1:0]};

  assign hit_o    = (addr_i[31:3] == BASE_ADDR[31:3]);
  assign wr_ctrl  = we_i & hit_o & ~addr_i[2];
  assign wr_data  = we_i & hit_o &  addr_i[2];
  assign send_req = wr_ctrl & wdata_i[0];
  assign done_clr = wr_ctrl & wdata_i[2];
  assign bit_end  = (baud_cnt_q == BIT_LAST);
  assign done_set = (state_q == ST_STOP) && bit_end;

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

  // Read data comes straight from the current register state, so a load in
  // the same cycle as a store sees the value from before that store.
  always_comb begin
    rdata_o = 32'd0;
    if (hit_o) begin
      if (addr_i[2]) begin
        rdata_o = {24'd0, txdata_q};
      end else begin
        rdata_o = {29'd0, done_q, busy_q, 1'b0};
      end
    end
  end

  // Next-state logic for the bus registers and the transmit FSM. The line
  // level is computed here one cycle ahead so tx_o can come from a flop.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    txdata_d   = wr_data ? wdata_i[7:0] : txdata_q;

    // A DONE set on the final STOP cycle beats a clear in the same cycle.
    if (done_set) begin
      done_d = 1'b1;
    end else if (done_clr) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (send_req) begin
          state_d    = ST_START;
          shift_d    = txdata_q;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          baud_cnt_d = 16'd0;
          bit_idx_d  = 3'd0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d    = ST_DATA;
          baud_cnt_d = 16'd0;
          bit_idx_d  = 3'd0;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d   = ST_STOP;
            bit_idx_d = 3'd0;
            tx_d      = 1'b1;
          end else begin
            // Shift right so the next data bit is always at position 0.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d    = ST_IDLE;
          baud_cnt_d = 16'd0;
          busy_d     = 1'b0;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = 16'd0;
        bit_idx_d  = 3'd0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // All state lives here. Reset aborts any frame and drives the line high on
  // the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      txdata_q   <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txdata_q   <= txdata_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_module_uart_tx_mmio.sv
// Testbench for module_uart_tx_mmio with BAUD_DIV = 4.
// Bus stores update a reference model that decides which frames must appear.
// Accepted frames go into a scoreboard queue, and a line monitor checks each
// frame it captures against the next queued byte.

module tb_module_uart_tx_mmio;

  localparam int          BD    = 4;
  localparam int          FRAME = 10 * BD;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        hit_o;
  logic        tx_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  int edge_count = 0;

  logic [7:0] exp_q[$];
  int         start_edges[$];

  // Reference model state: latched byte, frame end edges, last W1C edge
  logic [7:0] txdata_m;
  int         last_end;
  int         ends[$];
  int         clear_edge;

  // Monitor state
  bit          in_frame = 1'b0;
  bit          post_pending = 1'b0;
  int          sample_idx = 0;
  logic [39:0] line_v;
  logic [39:0] busy_v;

  module_uart_tx_mmio #(
    .BASE_ADDR(BASE),
    .BAUD_DIV (BD)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .rdata_o(rdata_o),
    .hit_o  (hit_o),
    .tx_o   (tx_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge counter: edge_count equals the index of the most recent rising edge.
  initial begin
    forever begin
      @(posedge clk_i);
      edge_count = edge_count + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    txdata_m   = 8'd0;
    last_end   = -1;
    ends.delete();
    clear_edge = 0;
  endtask

  // Expected load result after edge e, derived from the register map rules.
  function automatic logic [31:0] model_read(input logic [31:0] a, input int e);
    logic done_m;
    logic busy_m;
    if (a[31:3] != BASE[31:3]) return 32'd0;
    if (a[2]) return {24'd0, txdata_m};
    busy_m = (last_end >= 0) && (e < last_end);
    done_m = 1'b0;
    foreach (ends[i]) if (ends[i] >= clear_edge && ends[i] <= e) done_m = 1'b1;
    return {29'd0, done_m, busy_m, 1'b0};
  endfunction

  // One bus cycle; e returns the edge that sampled it.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d, output int e);
    we_i    = w;
    addr_i  = a;
    wdata_i = d;
    @(posedge clk_i);
    #1;
    e    = edge_count;
    we_i = 1'b0;
    if (rst_i === 1'b1 && w && a[31:3] == BASE[31:3]) begin
      if (a[2]) begin
        txdata_m = d[7:0];
      end else begin
        if (d[2]) clear_edge = e;
        // SEND is only accepted once the previous frame has fully ended.
        if (d[0] && e > last_end) begin
          exp_q.push_back(txdata_m);
          last_end = e + FRAME;
          ends.push_back(last_end);
        end
      end
    end
  endtask

  task automatic read_check(input string name, input logic [31:0] a);
    addr_i = a;
    we_i   = 1'b0;
    #1;
    checkOutput(name, 64'(rdata_o), 64'(model_read(a, edge_count)));
  endtask

  task automatic wait_edge(input int target);
    while (edge_count < target) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !in_frame && !post_pending) begin
        drained = 1'b1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    if (!drained) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got pending=%0d expected pending=0", exp_q.size());
    end
  endtask

  task automatic compare_frame();
    logic [7:0]  b;
    logic [63:0] exp_line;
    int          bitpos;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_frame: got line=%0h expected no frame", line_v);
    end else begin
      b = exp_q.pop_front();
      exp_line = 64'd0;
      for (int s = 0; s < FRAME; s++) begin
        bitpos = s / BD;
        if (bitpos == 0) exp_line[s] = 1'b0;
        else if (bitpos == 9) exp_line[s] = 1'b1;
        else exp_line[s] = b[bitpos-1];
      end
      checkOutput("frame_line", {24'd0, line_v}, exp_line);
      checkOutput("frame_busy", {24'd0, busy_v}, {24'd0, {40{1'b1}}});
    end
  endtask

  // Line monitor: samples on falling edges, captures one frame from the start
  // bit, then checks that the line is idle and busy is low right afterwards.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i !== 1'b1) begin
        in_frame     = 1'b0;
        post_pending = 1'b0;
        exp_q.delete();
      end else begin
        if (post_pending) begin
          post_pending = 1'b0;
          checkOutput("frame_tail", {62'd0, busy_o, tx_o}, 64'h1);
        end
        if (!in_frame && tx_o === 1'b0) begin
          in_frame   = 1'b1;
          sample_idx = 0;
          start_edges.push_back(edge_count);
        end
        if (in_frame) begin
          line_v[6'(sample_idx)] = tx_o;
          busy_v[6'(sample_idx)] = busy_o;
          sample_idx++;
          if (sample_idx == FRAME) begin
            in_frame     = 1'b0;
            post_pending = 1'b1;
            compare_frame();
          end
        end
      end
    end
  end

  initial begin
    int e;
    int n;
    int s;
    int cnt;
    rst_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 32'd0;
    wdata_i = 32'd0;
    model_reset();

    // Reset with random bus activity in the window
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 7)), $urandom, e);
    end
    checkOutput("reset_tx", 64'(tx_o), 64'h1);
    checkOutput("reset_busy", 64'(busy_o), 64'h0);
    rst_i = 1'b1;
    model_reset();
    read_check("reset_ctrl", BASE);
    read_check("reset_txdata", BASE + 32'd4);
    checkOutput("hit_base", 64'(hit_o), 64'h1);

    // Single frame of 0xA5
    start_edges.delete();
    applyStimulus(1'b1, BASE + 32'd4, 32'hA5, e);
    applyStimulus(1'b1, BASE, 32'h1, n);
    wait_drain(FRAME + 20);
    checkOutput("frame1_start", 64'(start_edges.size() > 0 ? start_edges[0] : -1), 64'(n));
    read_check("ctrl_done", BASE);
    applyStimulus(1'b1, BASE, 32'h4, e);
    read_check("ctrl_cleared", BASE);

    // SEND during a frame is ignored; TXDATA still updates
    start_edges.delete();
    applyStimulus(1'b1, BASE + 32'd4, 32'h3C, e);
    applyStimulus(1'b1, BASE, 32'h1, n);
    wait_edge(n + 10);
    applyStimulus(1'b1, BASE + 32'd4, 32'hFF, e);
    applyStimulus(1'b1, BASE, 32'h1, e);
    read_check("txdata_ff", BASE + 32'd4);
    read_check("ctrl_busy", BASE);
    wait_drain(FRAME + 20);
    wait_edge(edge_count + 60);
    checkOutput("single_frame_count", 64'(start_edges.size()), 64'd1);

    // Back-to-back frames and the DONE set/clear collision
    start_edges.delete();
    applyStimulus(1'b1, BASE + 32'd4, 32'h5A, e);
    applyStimulus(1'b1, BASE, 32'h1, n);
    applyStimulus(1'b1, BASE + 32'd4, 32'hC3, e);
    cnt = 0;
    while (busy_o !== 1'b0 && cnt < FRAME + 10) begin
      @(negedge clk_i);
      cnt++;
    end
    applyStimulus(1'b1, BASE, 32'h1, s);
    checkOutput("b2b_gap", 64'(s - n), 64'(FRAME + 1));
    applyStimulus(1'b1, BASE, 32'h4, e);
    checkOutput("b2b_start", 64'(start_edges.size() > 1 ? start_edges[1] : -1), 64'(s));
    read_check("ctrl_mid_frame2", BASE);
    wait_edge(s + FRAME - 1);
    applyStimulus(1'b1, BASE, 32'h4, e);
    read_check("done_set_wins", BASE);
    applyStimulus(1'b1, BASE, 32'h4, e);
    read_check("done_cleared", BASE);
    wait_drain(FRAME + 20);

    // Addresses just outside the window
    addr_i = BASE + 32'd8;
    #1;
    checkOutput("hit_above", 64'(hit_o), 64'h0);
    checkOutput("rdata_above", 64'(rdata_o), 64'h0);
    applyStimulus(1'b1, BASE + 32'd8, 32'h5, e);
    addr_i = BASE - 32'd4;
    #1;
    checkOutput("hit_below", 64'(hit_o), 64'h0);
    checkOutput("rdata_below", 64'(rdata_o), 64'h0);
    applyStimulus(1'b1, BASE - 32'd4, 32'hFF, e);
    read_check("decode_txdata", BASE + 32'd4);
    read_check("decode_ctrl", BASE);
    start_edges.delete();
    wait_edge(edge_count + 30);
    checkOutput("decode_no_frame", 64'(start_edges.size()), 64'd0);

    // Randomized frames with random spacing; some SENDs land mid-frame
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, BASE + 32'd4, 32'($urandom_range(0, 255)), e);
      applyStimulus(1'b1, BASE, 32'h1, e);
      wait_edge(edge_count + $urandom_range(0, 45));
      if ($urandom_range(0, 1) == 1) applyStimulus(1'b1, BASE + 32'd4, $urandom, e);
      read_check("rand_ctrl", BASE);
    end
    wait_drain(2 * FRAME + 50);
    read_check("rand_txdata", BASE + 32'd4);

    // Reset during data bit 3 of an all-zero byte
    applyStimulus(1'b1, BASE + 32'd4, 32'h00, e);
    applyStimulus(1'b1, BASE, 32'h1, n);
    wait_edge(n + 4 * BD + 1);
    checkOutput("pre_reset_tx", 64'(tx_o), 64'h0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("reset_mid_tx", 64'(tx_o), 64'h1);
    checkOutput("reset_mid_busy", 64'(busy_o), 64'h0);
    rst_i = 1'b1;
    model_reset();
    read_check("reset_mid_ctrl", BASE);
    read_check("reset_mid_txdata", BASE + 32'd4);
    start_edges.delete();
    wait_edge(edge_count + 50);
    checkOutput("reset_no_frame", 64'(start_edges.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
